// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a word-addressed RAM; independent read and write FSMs, one outstanding burst each.
// Optional ready throttling via an LFSR when AXI_RAM_BACKPRESSURE_EN is defined.
module axi_ram_slave #(
    parameter int          ADDR_BITS = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {R_IDLE, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    // WRAP only applies to legal lengths; anything else advances like INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [31:0] mask;
        logic [31:0] inc;
        mask = {26'b0, len[3:0], 2'b11};
        inc  = addr + 32'd4;
        next_addr = inc;
        if (burst == 2'b00)
            next_addr = addr;
        else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            next_addr = (addr & ~mask) | (inc & mask);
    endfunction

    function automatic logic [ADDR_BITS-1:0] word_idx(input logic [31:0] addr);
        word_idx = ADDR_BITS'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [DEPTH];

    logic bp_gate;
`ifdef AXI_RAM_BACKPRESSURE_EN
    logic [3:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 4'b1001;
        else     lfsr_q <= lfsr_d;
    end
    assign bp_gate = lfsr_q[0];
`else
    assign bp_gate = 1'b1;
`endif

    logic unused_sideband;
    assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    // ---------------- read path ----------------
    r_state_e              r_state_q, r_state_d;
    logic [31:0]           raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [1:0]            rburst_q, rburst_d;
    logic [3:0]            rid_q, rid_d;
    logic                  rerr_q, rerr_d;
    logic [31:0]           rdata_q;
    logic                  rd_en;
    logic [ADDR_BITS-1:0]  rd_idx;
    logic                  ar_fire, r_fire;

    assign arready = (r_state_q == R_IDLE) && bp_gate && !rst;
    assign rvalid  = (r_state_q == R_BURST);
    assign rlast   = rvalid && (rbeat_q == rlen_q);
    assign rresp   = rvalid ? {rerr_q, 1'b0} : 2'b00;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign ar_fire = arvalid && arready;
    assign r_fire  = rvalid && rready;

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rburst_d  = rburst_q;
        rid_d     = rid_q;
        rerr_d    = rerr_q;
        rd_en     = 1'b0;
        rd_idx    = word_idx(raddr_q);
        case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    raddr_d   = araddr;
                    rlen_d    = arlen;
                    rburst_d  = arburst;
                    rid_d     = arid;
                    rerr_d    = (arsize != 3'b010);
                    rbeat_d   = 8'd0;
                    rd_en     = 1'b1;
                    rd_idx    = word_idx(araddr);
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (r_fire) begin
                    if (rlast) begin
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = next_addr(raddr_q, rlen_q, rburst_q);
                        rbeat_d = rbeat_q + 8'd1;
                        rd_en   = 1'b1;
                        rd_idx  = word_idx(raddr_d);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rburst_q  <= '0;
            rid_q     <= '0;
            rerr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rburst_q  <= rburst_d;
            rid_q     <= rid_d;
            rerr_q    <= rerr_d;
        end
    end

    // Non-blocking memory update gives read-first behaviour on same-cycle collisions.
    always_ff @(posedge clk) begin
        if (rst)        rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rd_idx];
    end

    // ---------------- write path ----------------
    w_state_e    w_state_q, w_state_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [1:0]  wburst_q, wburst_d;
    logic [3:0]  bid_q, bid_d;
    logic        werr_q, werr_d;
    logic        aw_fire, w_fire, w_final;

    assign awready = (w_state_q == W_IDLE) && bp_gate && !rst;
    assign wready  = (w_state_q == W_DATA) && bp_gate && !rst;
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = bvalid ? {werr_q, 1'b0} : 2'b00;
    assign bid     = bid_q;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign w_final = (wbeat_q == wlen_q);

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        wburst_d  = wburst_q;
        bid_d     = bid_q;
        werr_d    = werr_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    waddr_d   = awaddr;
                    wlen_d    = awlen;
                    wburst_d  = awburst;
                    bid_d     = awid;
                    werr_d    = (awsize != 3'b010);
                    wbeat_d   = 8'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    if (wlast != w_final) werr_d = 1'b1;
                    if (w_final) begin
                        w_state_d = W_RESP;
                    end else begin
                        waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                        wbeat_d = wbeat_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wburst_q  <= '0;
            bid_q     <= '0;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            wburst_q  <= wburst_d;
            bid_q     <= bid_d;
            werr_q    <= werr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[word_idx(waddr_q)][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave: single/burst/wrap/fixed access, strobes, stalls, errors, reset.
module tb_axi_ram_slave;
    logic        clk, rst;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int tests = 0;
    int fails = 0;

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];
    logic [3:0]  rd_id   [16];
    logic [1:0]  wr_bresp;
    logic [3:0]  wr_bid;
    logic        hold_bvalid_ok, hold_awready_seen;
    logic        rd_first_ok, rd_stable;
    int          rd_bubbles;

    axi_ram_slave dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic timeout_fail(input string what);
        tests++;
        fails++;
        $display("FAIL timeout_%s: handshake not seen, required within budget", what);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] id, input int wlast_beat,
                             input int bready_delay);
        int   cyc;
        logic hs;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 50) begin hs = awready; @(posedge clk); #1; cyc++; end
        awvalid = 1'b0;
        if (!hs) timeout_fail("aw");
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = (i == wlast_beat); wvalid = 1'b1;
            cyc = 0; hs = 1'b0;
            while (!hs && cyc < 50) begin hs = wready; @(posedge clk); #1; cyc++; end
            if (!hs) timeout_fail("w");
        end
        wvalid = 1'b0; wlast = 1'b0;
        hold_bvalid_ok = 1'b1; hold_awready_seen = 1'b0;
        for (int k = 0; k < bready_delay; k++) begin
            if (bvalid !== 1'b1) hold_bvalid_ok = 1'b0;
            if (awready !== 1'b0) hold_awready_seen = 1'b1;
            @(posedge clk); #1;
        end
        bready = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 50) begin
            hs = bvalid;
            if (hs) begin wr_bresp = bresp; wr_bid = bid; end
            @(posedge clk); #1; cyc++;
        end
        bready = 1'b0;
        if (!hs) timeout_fail("b");
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id, input int stall_beat,
                            input int stall_cycles);
        int          cyc, i, stall_left;
        logic        hs, snap_taken, snap_l;
        logic [31:0] snap_d;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 50) begin hs = arready; @(posedge clk); #1; cyc++; end
        arvalid = 1'b0;
        if (!hs) timeout_fail("ar");
        rd_first_ok = (rvalid === 1'b1);
        i = 0; stall_left = stall_cycles; snap_taken = 1'b0; snap_l = 1'b0; snap_d = '0;
        rd_stable = 1'b1; rd_bubbles = 0; cyc = 0;
        while (i <= int'(len) && cyc < 200) begin
            if (rvalid === 1'b1) begin
                if (i == stall_beat && stall_left > 0) begin
                    rready = 1'b0;
                    if (!snap_taken) begin snap_d = rdata; snap_l = rlast; snap_taken = 1'b1; end
                    else if (rdata !== snap_d || rlast !== snap_l) rd_stable = 1'b0;
                    stall_left--;
                end else begin
                    rready = 1'b1;
                    if (snap_taken && i == stall_beat && (rdata !== snap_d || rlast !== snap_l))
                        rd_stable = 1'b0;
                    rd_data[i] = rdata; rd_last[i] = rlast; rd_resp[i] = rresp; rd_id[i] = rid;
                    i++;
                end
            end else begin
                rready = 1'b0;
                rd_bubbles++;
            end
            @(posedge clk); #1; cyc++;
        end
        rready = 1'b0;
        if (i <= int'(len)) timeout_fail("r");
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (arready !== 1'b0) begin fails++; $display("FAIL reset_arready_held got %b exp 0", arready); end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (arready !== 1'b1) begin fails++; $display("FAIL reset_arready got %b exp 1", arready); end
        tests++; if (awready !== 1'b1) begin fails++; $display("FAIL reset_awready got %b exp 1", awready); end
        tests++; if (wready !== 1'b0) begin fails++; $display("FAIL reset_wready got %b exp 0", wready); end
        tests++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin fails++; $display("FAIL reset_valids got r=%b b=%b exp 0 0", rvalid, bvalid); end
        tests++; if (rdata !== 32'h0 || rlast !== 1'b0) begin fails++; $display("FAIL reset_rdata got %h/%b exp 0/0", rdata, rlast); end
    endtask

    task automatic test_single;
        wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        axi_write(32'h40, 8'd0, 2'b01, 3'b010, 4'h5, 0, 0);
        tests++; if (wr_bresp !== 2'b00) begin fails++; $display("FAIL single_bresp got %b exp 00", wr_bresp); end
        tests++; if (wr_bid !== 4'h5) begin fails++; $display("FAIL single_bid got %h exp 5", wr_bid); end
        axi_read(32'h40, 8'd0, 2'b01, 3'b010, 4'hA, -1, 0);
        tests++; if (rd_first_ok !== 1'b1) begin fails++; $display("FAIL single_latency rvalid not high one cycle after AR"); end
        tests++; if (rd_data[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL single_rdata got %h exp deadbeef", rd_data[0]); end
        tests++; if (rd_last[0] !== 1'b1) begin fails++; $display("FAIL single_rlast got %b exp 1", rd_last[0]); end
        tests++; if (rd_resp[0] !== 2'b00) begin fails++; $display("FAIL single_rresp got %b exp 00", rd_resp[0]); end
        tests++; if (rd_id[0] !== 4'hA) begin fails++; $display("FAIL single_rid got %h exp a", rd_id[0]); end
    endtask

    task automatic test_incr;
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
        axi_write(32'h100, 8'd3, 2'b01, 3'b010, 4'h3, 3, 0);
        tests++; if (wr_bresp !== 2'b00) begin fails++; $display("FAIL incr_bresp got %b exp 00", wr_bresp); end
        axi_read(32'h100, 8'd3, 2'b01, 3'b010, 4'h2, -1, 0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
                fails++;
                $display("FAIL incr_beat%0d got %h/%b exp %h/%b", i, rd_data[i], rd_last[i], 32'(i + 1), (i == 3));
            end
        end
        tests++; if (rd_bubbles != 0) begin fails++; $display("FAIL incr_bubbles got %0d exp 0", rd_bubbles); end
    endtask

    task automatic test_strobe;
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
        axi_write(32'h200, 8'd0, 2'b01, 3'b010, 4'h1, 0, 0);
        wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
        axi_write(32'h200, 8'd0, 2'b01, 3'b010, 4'h1, 0, 0);
        wr_data[0] = 32'hFFFFFFFF; wr_strb[0] = 4'b0000;
        axi_write(32'h200, 8'd0, 2'b01, 3'b010, 4'h1, 0, 0);
        axi_read(32'h200, 8'd0, 2'b01, 3'b010, 4'h1, -1, 0);
        tests++; if (rd_data[0] !== 32'h11BB33DD) begin fails++; $display("FAIL strobe_merge got %h exp 11bb33dd", rd_data[0]); end
    endtask

    task automatic test_addressing;
        logic [31:0] exp_wrap [4];
        exp_wrap[0] = 32'd3; exp_wrap[1] = 32'd4; exp_wrap[2] = 32'd1; exp_wrap[3] = 32'd2;
        axi_read(32'h108, 8'd3, 2'b10, 3'b010, 4'h7, -1, 0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rd_data[i] !== exp_wrap[i]) begin
                fails++; $display("FAIL wrap_beat%0d got %h exp %h", i, rd_data[i], exp_wrap[i]);
            end
        end
        axi_read(32'h104, 8'd2, 2'b00, 3'b010, 4'h7, -1, 0);
        tests++;
        if (rd_data[0] !== 32'd2 || rd_data[1] !== 32'd2 || rd_data[2] !== 32'd2 || rd_last[2] !== 1'b1) begin
            fails++; $display("FAIL fixed_beats got %h %h %h last=%b exp 2 2 2 last=1", rd_data[0], rd_data[1], rd_data[2], rd_last[2]);
        end
        wr_data[0] = 32'hCAFEF00D; wr_strb[0] = 4'hF;
        axi_write(32'h4040, 8'd0, 2'b01, 3'b010, 4'h0, 0, 0);
        axi_read(32'h40, 8'd0, 2'b01, 3'b010, 4'h0, -1, 0);
        tests++; if (rd_data[0] !== 32'hCAFEF00D) begin fails++; $display("FAIL ram_top_wrap got %h exp cafef00d", rd_data[0]); end
    endtask

    task automatic test_backpressure;
        axi_read(32'h100, 8'd3, 2'b01, 3'b010, 4'h4, 1, 3);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
                fails++; $display("FAIL stall_beat%0d got %h/%b exp %h/%b", i, rd_data[i], rd_last[i], 32'(i + 1), (i == 3));
            end
        end
        tests++; if (rd_stable !== 1'b1) begin fails++; $display("FAIL stall_stable got %b exp 1", rd_stable); end
        wr_data[0] = 32'h55AA55AA; wr_strb[0] = 4'hF;
        axi_write(32'h300, 8'd0, 2'b01, 3'b010, 4'h9, 0, 5);
        tests++; if (hold_bvalid_ok !== 1'b1) begin fails++; $display("FAIL bhold_bvalid dropped while bready low, exp held 1"); end
        tests++; if (hold_awready_seen !== 1'b0) begin fails++; $display("FAIL bhold_awready got 1 exp 0"); end
        tests++; if (wr_bid !== 4'h9 || wr_bresp !== 2'b00) begin fails++; $display("FAIL bhold_resp got %h/%b exp 9/00", wr_bid, wr_bresp); end
    endtask

    task automatic test_errors;
        int   cyc;
        logic hs;
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h100 + 32'(i); wr_strb[i] = 4'hF; end
        axi_write(32'h300, 8'd3, 2'b01, 3'b010, 4'h6, 1, 0);
        tests++; if (wr_bresp !== 2'b10) begin fails++; $display("FAIL wlast_err_bresp got %b exp 10", wr_bresp); end
        axi_read(32'h30C, 8'd0, 2'b01, 3'b010, 4'h6, -1, 0);
        tests++; if (rd_data[0] !== 32'h103) begin fails++; $display("FAIL wlast_err_beats got %h exp 103", rd_data[0]); end
        wr_data[0] = 32'h77; wr_strb[0] = 4'hF;
        axi_write(32'h300, 8'd0, 2'b01, 3'b010, 4'h6, 0, 0);
        tests++; if (wr_bresp !== 2'b00) begin fails++; $display("FAIL err_cleared_bresp got %b exp 00", wr_bresp); end
        axi_read(32'h100, 8'd0, 2'b01, 3'b000, 4'h6, -1, 0);
        tests++; if (rd_resp[0] !== 2'b10 || rd_data[0] !== 32'd1) begin fails++; $display("FAIL size_err got %b/%h exp 10/1", rd_resp[0], rd_data[0]); end
        wr_data[0] = 32'h88; wr_strb[0] = 4'hF;
        axi_write(32'h304, 8'd0, 2'b01, 3'b001, 4'h6, 0, 0);
        tests++; if (wr_bresp !== 2'b10) begin fails++; $display("FAIL awsize_err got %b exp 10", wr_bresp); end

        araddr = 32'h100; arlen = 8'd3; arburst = 2'b01; arsize = 3'b010; arid = 4'h1; arvalid = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 50) begin hs = arready; @(posedge clk); #1; cyc++; end
        arvalid = 1'b0;
        if (!hs) timeout_fail("rst_ar");
        tests++; if (rvalid !== 1'b1) begin fails++; $display("FAIL rst_burst_started got %b exp 1", rvalid); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin fails++; $display("FAIL rst_abort got rvalid=%b rlast=%b exp 0 0", rvalid, rlast); end
        rst = 1'b0;
        rready = 1'b1;
        @(posedge clk); #1;
        tests++; if (arready !== 1'b1 || rvalid !== 1'b0) begin fails++; $display("FAIL rst_recover got arready=%b rvalid=%b exp 1 0", arready, rvalid); end
        rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        test_reset();
        test_single();
        test_incr();
        test_strobe();
        test_addressing();
        test_backpressure();
        test_errors();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
